bm_mem_arbiter: RTL and testbench
=================================

# bm_mem_arbiter

Round-robin arbiter sharing the single-port bin storage RAM among the bin-manager sub-blocks (rdinfo, load_bin, update_bin, bkt_across_bin). It grants one requester at a time and holds the grant for a burst. When the requester drops its request, or a burst limit is reached while others wait, the grant hands off. Read data is returned to the requester that issued the read, tagged by issue cycle. The arbiter sits between those sub-blocks and the RAM, beneath the bin-manager controller FSM.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters; index 0 = rdinfo, 1 = load, 2 = update, 3 = bkt_across_bin
- WIDTH_ADDR, 12, RAM address width
- WIDTH_DATA, 32, RAM data width
- MEM_RD_LAT, 1, RAM read latency in cycles (1..4)
- MAX_BURST, 64, maximum accepted accesses per grant when another requester is waiting

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- req_i  in  NUM_REQ  per-requester request, level
- we_i  in  NUM_REQ  per-requester write enable
- addr_i  in  NUM_REQ*WIDTH_ADDR  flattened addresses; requester k at [k*WIDTH_ADDR +: WIDTH_ADDR]
- wdata_i  in  NUM_REQ*WIDTH_DATA  flattened write data
- gnt_o  out  NUM_REQ  registered one-hot grant (or all zero)
- rvalid_o  out  NUM_REQ  one-hot read-data valid
- rdata_o  out  WIDTH_DATA  read data, shared by all requesters
- mem_en_o, mem_we_o  out  1  RAM enable / write enable
- mem_addr_o  out  WIDTH_ADDR  RAM address
- mem_wdata_o  out  WIDTH_DATA  RAM write data
- mem_rdata_i  in  WIDTH_DATA  RAM read data, valid MEM_RD_LAT cycles after mem_en_o with mem_we_o=0
- busy_o  out  1  a grant is held or a read is in flight

## Operation
- Access rule: requester k performs exactly one access in every cycle with req_i[k] && gnt_o[k]. In that cycle mem_en_o=1 and mem_we_o/addr/wdata are driven combinationally from k's slice. In every other cycle mem_en_o=0 and the other mem outputs are 0.
- FSM with two states:
  - IDLE: gnt_o=0. If req_i≠0, pick a winner and go to GRANT; gnt_o[winner]=1 from the next cycle.
  - GRANT: owner = index of the set gnt_o bit.
    - Release: if req_i[owner]=0, or burst_cnt==MAX_BURST with another req_i bit set, pick a new winner among requests other than the owner (on release with no other request, go to IDLE). The new grant appears next cycle.
    - Solo owner: at burst_cnt==MAX_BURST with no other requester, the owner keeps the grant and burst_cnt restarts at 0.
- Round-robin: the search starts at last_owner+1 and wraps modulo NUM_REQ. last_owner updates whenever a grant is issued.
- burst_cnt: counts accepted accesses under the current grant, width clog2(MAX_BURST+1), and clears on every new grant.
- Read return: a tag pipeline of MEM_RD_LAT stages carries {valid, owner}. rvalid_o[tag.owner]=1 and rdata_o=mem_rdata_i in the cycle the tag exits. Read returns may overlap a handoff, so returns keep their issue-time tag.
- Preempted requester: keeps req_i high and waits for its next grant. It must not treat the lost grant as completion.

## Timing
- Reset values:
  - gnt_o=0, rvalid_o=0, rdata_o=0, mem_* =0, busy_o=0
  - state=IDLE, burst_cnt=0, tag pipeline cleared
  - last_owner=NUM_REQ-1, so requester 0 wins the first tie
- Reset mid-burst drops the grant the next cycle, and in-flight reads are discarded with no rvalid_o.
- Latencies:
  - req_i rising in IDLE gives gnt_o one cycle later.
  - A read issued in cycle t returns rvalid_o in cycle t+MEM_RD_LAT.
- Handoff cost: the owner deasserts req_i in cycle n and the new owner's gnt_o is high in cycle n+1. There is one dead RAM cycle (cycle n) and no IDLE bubble.
- Simultaneous events: if the owner drops while several requests are pending, the lowest index after last_owner (with wrap) wins. A requester that drops req_i while not granted has no effect.
- gnt_o is never multi-hot. busy_o = (state==GRANT) | any tag valid.

## Structure
- Shared package bm_pkg: state enum (ARB_IDLE, ARB_GRANT), requester index constants (REQ_RDINFO..REQ_BKT), and a clog2 function.
- Sub-module bm_rr_pick: combinational round-robin picker with inputs req, mask (owner excluded) and last_owner, and outputs onehot and idx. It is instantiated once.
- The tag pipeline and FSM live in bm_mem_arbiter.

## Test plan
- Single request: after reset, req_i=4'b0010 held for 3 reads at addresses 5, 6, 7 with MEM_RD_LAT=1. gnt_o[1] is high from cycle 1. rvalid_o[1] pulses in cycles 2–4 with the RAM contents of 5, 6, 7.
- Round-robin fairness: req_i=4'b1111, each requester holding one access then dropping. Grant order is 0, 1, 2, 3, 0, with each new grant one cycle after the previous drop.
- Preemption: MAX_BURST=4, requester 2 streaming writes and requester 0 requesting from cycle 2. After 4 accepted writes gnt_o switches to 4'b0001, and requester 2 regains the grant after 0 releases.
- Solo burst: MAX_BURST=4 with only requester 3 streaming 10 accesses. gnt_o[3] stays high for all 10 and all 10 RAM accesses complete.
- Read across handoff: MEM_RD_LAT=3. Requester 1 issues its last read in cycle t and releases; requester 2 is granted in t+1. rvalid_o[1] is high at t+3, not rvalid_o[2].
- Reset mid-operation: rst in the middle of a read burst. The next cycle has gnt_o=0 and mem_en_o=0, and no rvalid_o appears afterwards.

Source files
------------

// File: rtl/bm_pkg.sv
// bm_pkg: shared types, requester indices and helpers for the bin-manager RAM arbiter
package bm_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    localparam int REQ_RDINFO = 0;
    localparam int REQ_LOAD   = 1;
    localparam int REQ_UPDATE = 2;
    localparam int REQ_BKT    = 3;

    function automatic int clog2(input int v);
        for (int r = 0; r < 32; r++)
            if ((1 << r) >= v) return r;
        return 32;
    endfunction

endpackage

// File: rtl/bm_rr_pick.sv
// bm_rr_pick: combinational round-robin picker searching from last_owner+1 with wrap
module bm_rr_pick
    import bm_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] last_owner,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    logic [N-1:0]  cand;
    logic [IW-1:0] j;
    logic          found;

    assign cand = req & mask;

    always_comb begin
        onehot = '0;
        idx = last_owner;
        found = 1'b0;
        j = '0;
        for (int i = 1; i <= N; i++) begin
            j = IW'((int'(last_owner) + i) % N);
            if (!found && cand[j]) begin
                found = 1'b1;
                idx = j;
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bm_mem_arbiter.sv
// bm_mem_arbiter: round-robin burst arbiter sharing the single-port bin storage RAM
module bm_mem_arbiter
    import bm_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH_ADDR = 12,
    parameter int WIDTH_DATA = 32,
    parameter int MEM_RD_LAT = 1,
    parameter int MAX_BURST  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ*WIDTH_ADDR-1:0] addr_i,
    input  logic [NUM_REQ*WIDTH_DATA-1:0] wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic [WIDTH_DATA-1:0]         rdata_o,
    output logic                          mem_en_o,
    output logic                          mem_we_o,
    output logic [WIDTH_ADDR-1:0]         mem_addr_o,
    output logic [WIDTH_DATA-1:0]         mem_wdata_o,
    input  logic [WIDTH_DATA-1:0]         mem_rdata_i,
    output logic                          busy_o
);

    localparam int IW = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
    localparam int BW = clog2(MAX_BURST + 1);

    arb_state_t state, state_n;
    logic [NUM_REQ-1:0] gnt_n, own_bit, mask, pick_oh;
    logic [IW-1:0] last_owner, last_owner_n, pick_idx;
    logic [BW-1:0] burst_cnt, burst_n;
    logic [MEM_RD_LAT-1:0] tag_v;
    logic [MEM_RD_LAT-1:0][IW-1:0] tag_o;
    logic accept, others, limit, hand_off, issue;

    // while granted, last_owner is the current owner
    assign own_bit = NUM_REQ'(1) << last_owner;
    assign accept = state == ARB_GRANT && req_i[last_owner];
    assign others = |(req_i & ~own_bit);
    assign limit = accept && burst_cnt == BW'(MAX_BURST - 1);
    assign mask = state == ARB_GRANT ? ~own_bit : '1;

    bm_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req(req_i),
        .mask(mask),
        .last_owner(last_owner),
        .onehot(pick_oh),
        .idx(pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
            gnt_o <= '0;
            last_owner <= IW'(NUM_REQ - 1);
            burst_cnt <= '0;
            tag_v <= '0;
            tag_o <= '0;
        end else begin
            state <= state_n;
            gnt_o <= gnt_n;
            last_owner <= last_owner_n;
            burst_cnt <= burst_n;
            tag_v[0] <= accept && !we_i[last_owner];
            tag_o[0] <= last_owner;
            for (int i = 1; i < MEM_RD_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_o[i] <= tag_o[i-1];
            end
        end
    end

    // the access that reaches MAX_BURST is the last one when someone else waits
    always_comb begin
        hand_off = state == ARB_GRANT && (!req_i[last_owner] || (limit && others));
        issue = (state == ARB_IDLE || hand_off) && |pick_oh;
        state_n = issue ? ARB_GRANT : hand_off ? ARB_IDLE : state;
        gnt_n = issue ? pick_oh : hand_off ? '0 : gnt_o;
        last_owner_n = issue ? pick_idx : last_owner;
        burst_n = (issue || limit) ? '0 : burst_cnt + BW'(accept);
    end

    always_comb begin
        mem_en_o = accept;
        mem_we_o = accept && we_i[last_owner];
        mem_addr_o = accept ? addr_i[last_owner*WIDTH_ADDR +: WIDTH_ADDR] : '0;
        mem_wdata_o = accept ? wdata_i[last_owner*WIDTH_DATA +: WIDTH_DATA] : '0;
        rvalid_o = tag_v[MEM_RD_LAT-1] ? NUM_REQ'(1) << tag_o[MEM_RD_LAT-1] : '0;
        rdata_o = tag_v[MEM_RD_LAT-1] ? mem_rdata_i : '0;
        busy_o = state == ARB_GRANT || |tag_v;
    end

endmodule

// File: tb/tb_bm_mem_arbiter.sv
// tb_bm_mem_arbiter: table, directed and randomized model-based checks of bm_mem_arbiter
module tb_bm_mem_arbiter;

    localparam int N = 4, WA = 12, WD = 32, LAT = 3, MB = 4;

    logic clk = 1'b0, rst = 1'b1;
    logic [N-1:0] req = '0, we = '0;
    logic [WA-1:0] addr_a [N];
    logic [WD-1:0] wdata_a [N];
    logic [N*WA-1:0] addr_i;
    logic [N*WD-1:0] wdata_i;
    logic [N-1:0] gnt, rvalid;
    logic [WD-1:0] rdata, mem_wdata, mem_rdata;
    logic [WA-1:0] mem_addr;
    logic mem_en, mem_we, busy;

    logic [WD-1:0] ram [1<<WA];
    logic [WD-1:0] ref_mem [1<<WA];
    logic [WD-1:0] rpipe [LAT];

    int tests = 0, fails = 0, cyc = 0, cnt = 0;
    bit model_on = 1'b0;

    typedef struct { int due; int who; logic [WD-1:0] data; } rd_t;
    rd_t rq[$];
    int m_own = -1, m_last = N - 1, m_cnt = 0;

    typedef struct { logic [N-1:0] req; logic [N-1:0] gnt; logic en; } vec_t;
    vec_t tbl [12];
    logic [N-1:0] pre_g [9];

    always #5 clk = ~clk;

    always_comb begin
        addr_i = '0;
        wdata_i = '0;
        for (int k = 0; k < N; k++) begin
            addr_i[k*WA +: WA] = addr_a[k];
            wdata_i[k*WD +: WD] = wdata_a[k];
        end
    end

    bm_mem_arbiter #(.NUM_REQ(N), .WIDTH_ADDR(WA), .WIDTH_DATA(WD), .MEM_RD_LAT(LAT), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr_i), .wdata_i(wdata_i),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .mem_en_o(mem_en), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    // RAM with fixed read latency LAT
    always @(posedge clk) begin
        rpipe[0] <= ram[mem_addr];
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
        if (mem_en && mem_we) ram[mem_addr] = mem_wdata;
    end
    assign mem_rdata = rpipe[LAT-1];

    function automatic logic [WD-1:0] init_val(int a);
        return (WD'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int pick(logic [N-1:0] r, int excl);
        int j;
        for (int i = 1; i <= N; i++) begin
            j = (m_last + i) % N;
            if (r[j] && j != excl) return j;
        end
        return -1;
    endfunction

    // reference: owner, accesses-this-grant count and a queue of reads awaiting return
    task automatic model_step();
        logic [N-1:0] eg = '0, erv = '0;
        logic een, ewe;
        logic [WA-1:0] ea = '0;
        logic [WD-1:0] ewd = '0, erd = '0;
        int w;
        if (m_own >= 0) eg[m_own] = 1'b1;
        een = m_own >= 0 && req[m_own];
        ewe = een && we[m_own];
        if (een) begin
            ea = addr_a[m_own];
            ewd = wdata_a[m_own];
        end
        if (rq.size() > 0 && rq[0].due == cyc) begin
            erv[rq[0].who] = 1'b1;
            erd = rq[0].data;
        end
        if (model_on) begin
            chk("gnt", gnt, eg);
            chk("mem_en", mem_en, een);
            chk("mem_we", mem_we, ewe);
            chk("mem_addr", mem_addr, ea);
            chk("mem_wdata", mem_wdata, ewd);
            chk("rvalid", rvalid, erv);
            chk("rdata", rdata, erd);
            chk("busy", busy, m_own >= 0 || rq.size() > 0);
        end
        if (erv != 0) void'(rq.pop_front());
        if (ewe) ref_mem[ea] = ewd;
        else if (een && !rst) rq.push_back('{cyc + LAT, m_own, ref_mem[ea]});
        if (rst) begin
            m_own = -1;
            m_last = N - 1;
            m_cnt = 0;
            rq.delete();
        end else if (m_own < 0) begin
            w = pick(req, -1);
            if (w >= 0) begin
                m_own = w;
                m_last = w;
                m_cnt = 0;
            end
        end else begin
            if (een) m_cnt++;
            if (!req[m_own] || (m_cnt == MB && (req & ~(N'(1) << m_own)) != 0)) begin
                w = pick(req, m_own);
                m_own = w;
                if (w >= 0) begin
                    m_last = w;
                    m_cnt = 0;
                end
            end else if (m_cnt == MB) m_cnt = 0;
        end
        cyc++;
    endtask

    task automatic at_neg(); @(negedge clk); model_step(); endtask
    task automatic tick(); @(posedge clk); #1; endtask
    task automatic cycle(); at_neg(); tick(); endtask
    task automatic do_reset(); rst = 1'b1; req = '0; cycle(); rst = 1'b0; endtask
    task automatic drain(int n); req = '0; repeat (n) cycle(); endtask

    initial begin
        tbl = '{'{4'b1111, 4'b0000, 1'b0}, '{4'b1111, 4'b0001, 1'b1}, '{4'b1110, 4'b0001, 1'b0},
                '{4'b1110, 4'b0010, 1'b1}, '{4'b1100, 4'b0010, 1'b0}, '{4'b1100, 4'b0100, 1'b1},
                '{4'b1000, 4'b0100, 1'b0}, '{4'b1000, 4'b1000, 1'b1}, '{4'b0001, 4'b1000, 1'b0},
                '{4'b0001, 4'b0001, 1'b1}, '{4'b0000, 4'b0001, 1'b0}, '{4'b0000, 4'b0000, 1'b0}};
        pre_g = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0001, 4'b0100, 4'b0100};
        for (int a = 0; a < (1 << WA); a++) begin
            ram[a] = init_val(a);
            ref_mem[a] = init_val(a);
        end
        for (int k = 0; k < N; k++) begin
            addr_a[k] = '0;
            wdata_a[k] = '0;
        end
        #1;
        repeat (2) cycle();
        rst = 1'b0;
        model_on = 1'b1;

        at_neg();
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", rdata, 0);
        tick();

        // single requester: three reads at 5, 6, 7
        for (int k = 0; k <= 4 + LAT; k++) begin
            req = (k <= 3) ? 4'b0010 : 4'b0000;
            addr_a[1] = WA'(4 + k);
            at_neg();
            chk("sr_gnt", gnt, (k >= 1 && k <= 4) ? 4'b0010 : 4'b0000);
            chk("sr_rvalid", rvalid, (k >= 1 + LAT && k <= 3 + LAT) ? 4'b0010 : 4'b0000);
            chk("sr_rdata", rdata, (k >= 1 + LAT && k <= 3 + LAT) ? init_val(4 + k - LAT) : 0);
            tick();
        end
        drain(2);

        // round-robin fairness
        do_reset();
        for (int i = 0; i < 12; i++) begin
            req = tbl[i].req;
            at_neg();
            chk("rr_gnt", gnt, tbl[i].gnt);
            chk("rr_en", mem_en, tbl[i].en);
            tick();
        end

        // preemption of a writing stream by requester 0
        cnt = 0;
        for (int k = 0; k < 9; k++) begin
            req = (k < 2 || k > 5) ? 4'b0100 : 4'b0101;
            we = 4'b0100;
            addr_a[2] = WA'(100 + k);
            wdata_a[2] = WD'(k);
            addr_a[0] = WA'(120 + k);
            at_neg();
            chk("pre_gnt", gnt, pre_g[k]);
            if (k <= 4 && mem_en && mem_we) cnt++;
            tick();
        end
        chk("pre_writes", cnt, 4);
        we = '0;
        drain(LAT + 1);

        // solo owner runs past the burst limit
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            req = (k <= 10) ? 4'b1000 : 4'b0000;
            we = {k[0], 3'b000};
            addr_a[3] = WA'(200 + k);
            wdata_a[3] = WD'(32'hBEEF_0000 + k);
            at_neg();
            chk("solo_gnt", gnt, (k >= 1) ? 4'b1000 : 4'b0000);
            if (k >= 1 && k <= 10 && mem_en) cnt++;
            tick();
        end
        chk("solo_acc", cnt, 10);
        we = '0;
        drain(LAT + 1);

        // read returns across a burst-limit handoff
        do_reset();
        for (int k = 0; k <= 5 + LAT; k++) begin
            req = (k < 5) ? 4'b0110 : 4'b0100;
            addr_a[1] = WA'(300 + k);
            addr_a[2] = WA'(400 + k);
            at_neg();
            if (k == 5) chk("ho_gnt", gnt, 4'b0100);
            if (k == 4 + LAT) begin
                chk("ho_rvalid1", rvalid, 4'b0010);
                chk("ho_rdata1", rdata, init_val(304));
            end
            if (k == 5 + LAT) chk("ho_rvalid2", rvalid, 4'b0100);
            tick();
        end
        drain(LAT + 1);

        // reset in the middle of a read burst
        for (int k = 0; k <= 5 + LAT; k++) begin
            rst = (k == 3);
            req = (k <= 3) ? 4'b0001 : 4'b0000;
            addr_a[0] = WA'(500 + k);
            at_neg();
            if (k == 4) begin
                chk("mr_gnt", gnt, 0);
                chk("mr_en", mem_en, 0);
            end
            if (k >= 4) chk("mr_rvalid", rvalid, 0);
            tick();
        end
        rst = 1'b0;

        // randomized traffic against the reference
        req = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 5) == 0) req[k] = ~req[k];
                addr_a[k] = WA'($urandom_range(0, 15));
                wdata_a[k] = $urandom;
            end
            we = N'($urandom);
            rst = ($urandom_range(0, 249) == 0);
            cycle();
        end
        rst = 1'b0;
        drain(LAT + 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
